core_lsu_op_arb: RTL and testbench

CORE_LSU_OP_ARB -- requirements
Module: core_lsu_op_arb

---
 rtl/core_lsu_op_arb.sv | 126 ++++++++++++
 tb/tb_core_lsu_op_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu_op_arb.sv
// Arbitrates cache-op requests from two LSU pipes onto the single dram-manager op port.
// Optional LSU_OP_ARB_RR_EN replaces fixed priority + starvation promotion with round-robin.
module core_lsu_op_arb #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid_i,
   input  logic [3:0]  req0_type_i,
   input  logic [31:0] req0_addr_i,
   output logic        req0_done_o,
   input  logic        req1_valid_i,
   input  logic [3:0]  req1_type_i,
   input  logic [31:0] req1_addr_i,
   output logic        req1_done_o,
   output logic        dm_op_valid_o,
   output logic [3:0]  dm_op_type_o,
   output logic [31:0] dm_op_addr_o,
   input  logic        dm_op_ready_i,
   output logic        owner_o,
   output logic        busy_o
);

   // state   | meaning
   // IDLE    | sampling requests, grant on any valid
   // BUSY    | op presented to dram manager, waiting for ready
   // DONE    | one-cycle done pulse to the owner, no grant
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_BUSY = 3'b010,
      ST_DONE = 3'b100
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  type_q, type_d;
   logic [31:0] addr_q, addr_d;
   logic        owner_q, owner_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic        conflict;
   logic        win;

`ifndef LSU_OP_ARB_RR_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
   logic [3:0]  starve_q, starve_d;
`endif

   assign conflict = req0_valid_i & req1_valid_i;

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      addr_d  = addr_q;
      owner_d = owner_q;
`ifdef LSU_OP_ARB_RR_EN
      win = conflict ? ~owner_q : req1_valid_i;
`else
      starve_d = starve_q;
      // younger pipe wins unless the older one has lost STARVE_LIMIT times in a row
      win = conflict ? (starve_q < STARVE_LIM) : req1_valid_i;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req0_valid_i | req1_valid_i) begin
               state_d = ST_BUSY;
               owner_d = win;
               type_d  = win ? req1_type_i : req0_type_i;
               addr_d  = win ? req1_addr_i : req0_addr_i;
`ifndef LSU_OP_ARB_RR_EN
               if (!win) begin
                  starve_d = 4'd0;
               end else if (conflict && (starve_q != 4'hf)) begin
                  starve_d = starve_q + 4'd1;
               end
`endif
            end
         end
         ST_BUSY: begin
            if (dm_op_ready_i) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (!rst_n) begin
         state_d = ST_IDLE;
         type_d  = 4'd0;
         addr_d  = 32'd0;
         owner_d = 1'b0;
`ifndef LSU_OP_ARB_RR_EN
         starve_d = 4'd0;
`endif
      end
      // outputs are registered copies of the next-state decode
      valid_d = (state_d == ST_BUSY);
      busy_d  = (state_d != ST_IDLE);
      done0_d = (state_d == ST_DONE) & ~owner_d;
      done1_d = (state_d == ST_DONE) & owner_d;
   end

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
`ifndef LSU_OP_ARB_RR_EN
      starve_q <= starve_d;
`endif
   end

   assign dm_op_valid_o = valid_q;
   assign dm_op_type_o  = type_q;
   assign dm_op_addr_o  = addr_q;
   assign owner_o       = owner_q;
   assign busy_o        = busy_q;
   assign req0_done_o   = done0_q;
   assign req1_done_o   = done1_q;

endmodule

// File: tb/tb_core_lsu_op_arb.sv
// Self-checking bench for core_lsu_op_arb: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_core_lsu_op_arb;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0v = 1'b0, r1v = 1'b0, rdy = 1'b0;
   logic [3:0]  r0t = 4'd0, r1t = 4'd0;
   logic [31:0] r0a = 32'd0, r1a = 32'd0;
   logic        d0, d1, ov, own, bsy;
   logic [3:0]  ot;
   logic [31:0] oa;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: phase 0 = idle, 1 = op outstanding, 2 = completion cycle
   int          m_phase = 0;
   int          m_cnt   = 0;
   int          m_owner = 0;
   logic [3:0]  m_type  = 4'd0;
   logic [31:0] m_addr  = 32'd0;

   core_lsu_op_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(r0v), .req0_type_i(r0t), .req0_addr_i(r0a), .req0_done_o(d0),
      .req1_valid_i(r1v), .req1_type_i(r1t), .req1_addr_i(r1a), .req1_done_o(d1),
      .dm_op_valid_o(ov), .dm_op_type_o(ot), .dm_op_addr_o(oa),
      .dm_op_ready_i(rdy), .owner_o(own), .busy_o(bsy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_update();
      int w;
      bit both;
      if (!rst_n) begin
         m_phase = 0; m_cnt = 0; m_owner = 0; m_type = 4'd0; m_addr = 32'd0;
      end else if (m_phase == 0) begin
         if (r0v || r1v) begin
            both = r0v && r1v;
`ifdef LSU_OP_ARB_RR_EN
            w = both ? 1 - m_owner : (r1v ? 1 : 0);
`else
            w = both ? ((m_cnt >= LIMIT) ? 0 : 1) : (r1v ? 1 : 0);
            if (w == 0) m_cnt = 0;
            else if (both) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
`endif
            m_owner = w;
            m_type  = (w == 1) ? r1t : r0t;
            m_addr  = (w == 1) ? r1a : r0a;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (rdy) m_phase = 2;
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk("op_valid", {31'd0, ov},  {31'd0, m_phase == 1});
      chk("busy",     {31'd0, bsy}, {31'd0, m_phase != 0});
      chk("done0",    {31'd0, d0},  {31'd0, (m_phase == 2) && (m_owner == 0)});
      chk("done1",    {31'd0, d1},  {31'd0, (m_phase == 2) && (m_owner == 1)});
      chk("owner",    {31'd0, own}, m_owner);
      chk("op_type",  {28'd0, ot},  {28'd0, m_type});
      chk("op_addr",  oa,           m_addr);
      chk("done_excl", {31'd0, d0 & d1}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0; rdy = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int ng;
      int exp_own;
      logic prev_ov;

      // reset state
      do_reset();
      chk("rst_valid", {31'd0, ov}, 32'd0);
      chk("rst_owner", {31'd0, own}, 32'd0);

      // single requester 0, ready two cycles after op_valid
      r0v = 1'b1; r0t = 4'b0001; r0a = 32'h1000_0040;
      step();                                   // t+1
      chk("s_valid_t1", {31'd0, ov}, 32'd1);
      step();                                   // t+2
      step();                                   // t+3
      chk("s_valid_t3", {31'd0, ov}, 32'd1);
      rdy = 1'b1;
      step();                                   // t+4
      chk("s_done_t4", {31'd0, d0}, 32'd1);
      chk("s_owner", {31'd0, own}, 32'd0);
      chk("s_valid_t4", {31'd0, ov}, 32'd0);
      r0v = 1'b0; rdy = 1'b0;
      step();
      chk("s_idle", {31'd0, bsy}, 32'd0);

      // simultaneous request: younger first, then older
      do_reset();
      r0v = 1'b1; r0t = 4'h2; r0a = 32'h0000_0a00;
      r1v = 1'b1; r1t = 4'h5; r1a = 32'h0000_0b00;
      rdy = 1'b1;
      step();
`ifdef LSU_OP_ARB_RR_EN
      chk("both_first", {31'd0, own}, 32'd1);
`else
      chk("both_first", {31'd0, own}, 32'd1);
`endif
      step();
      chk("both_done1", {31'd0, d1}, 32'd1);
      r1v = 1'b0;
      step();                                   // IDLE, req0 sampled
      step();
      chk("both_second", {31'd0, own}, 32'd0);
      chk("both_addr", oa, 32'h0000_0a00);
      r0v = 1'b0;
      step();
      step();

      // continuous contention: starvation promotion (or round-robin alternation)
      do_reset();
      r0v = 1'b1; r0a = 32'h0000_1100; r0t = 4'h1;
      r1v = 1'b1; r1a = 32'h0000_2200; r1t = 4'h2;
      rdy = 1'b1;
      ng = 0;
      prev_ov = 1'b0;
      for (int c = 0; c < 100 && ng < 6; c++) begin
         step();
         if (ov && !prev_ov) begin
`ifdef LSU_OP_ARB_RR_EN
            exp_own = (ng % 2 == 0) ? 1 : 0;
`else
            exp_own = (ng == LIMIT) ? 0 : 1;
`endif
            chk("cont_owner", {31'd0, own}, exp_own);
            chk("cont_addr", oa, (exp_own == 1) ? 32'h0000_2200 : 32'h0000_1100);
            ng++;
         end
         prev_ov = ov;
      end
      chk("cont_grants", ng, 6);

      // reset in the middle of an op
      do_reset();
      r0v = 1'b1; r1v = 1'b0; rdy = 1'b0; r0a = 32'h0000_3300;
      step();
      step();
      chk("mid_busy", {31'd0, bsy}, 32'd1);
      rst_n = 1'b0;
      step();
      chk("mid_valid", {31'd0, ov}, 32'd0);
      chk("mid_bsy", {31'd0, bsy}, 32'd0);
      chk("mid_done", {31'd0, d0 | d1}, 32'd0);
      rst_n = 1'b1; r0v = 1'b0; rdy = 1'b1;
      step();
      chk("mid_nodone", {31'd0, d0 | d1}, 32'd0);
      // counter must be 0 after reset: conflict goes to req1
      r0v = 1'b1; r1v = 1'b1; r1a = 32'h0000_4400;
      step();
      chk("mid_post_owner", {31'd0, own}, 32'd1);
      r0v = 1'b0; r1v = 1'b0;
      step();                                   // DONE, ready high in DONE
      step();                                   // IDLE, ready high in IDLE
      chk("rdy_idle_bsy", {31'd0, bsy}, 32'd0);
      step();
      chk("rdy_idle_done", {31'd0, d0 | d1}, 32'd0);
      rdy = 1'b0;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         r0v = ($urandom_range(0, 9) < 7);
         r1v = ($urandom_range(0, 9) < 7);
         r0t = 4'($urandom);
         r1t = 4'($urandom);
         r0a = $urandom;
         r1a = $urandom;
         rdy = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
